// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - ID-stage branch resolver with direct-mapped BHT/BTB predictor
//
// Purpose:
//    Resolves RV32I conditional branches, JAL and JALR in ID using forwarded
//    operands, raises a redirect on mispredict, and owns a direct-mapped
//    predictor (2-bit counter + target per entry) that is read at IF and
//    trained at ID. Also keeps resolve / mispredict statistics.
//
// Ports:
//    clk, rst_n                    clock (rising edge), async active-low reset
//    ifPc -> predTaken/predTarget  combinational IF lookup
//    idValid, idPc, idPredTaken,   ID instruction and the prediction that
//    idPredTarget                  travelled with it through IF_ID
//    opcode, funct3, immValue      decoder fields
//    source1/2, select1/2,         register operands and forward selects
//    wbALU, wbALUMem               forward data paths
//    redirectValid/redirectAddr    mispredict flush and correct next PC
//    branchCount, mispredictCount  wrapping statistics counters

module branch_predict_unit #(
   parameter int XLEN       = 32,
   parameter int INDEX_BITS = 6,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   ifPc,
   output logic              predTaken,
   output logic [XLEN-1:0]   predTarget,
   input  logic              idValid,
   input  logic [XLEN-1:0]   idPc,
   input  logic              idPredTaken,
   input  logic [XLEN-1:0]   idPredTarget,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   immValue,
   input  logic [XLEN-1:0]   source1,
   input  logic [XLEN-1:0]   source2,
   input  logic [1:0]        select1,
   input  logic [1:0]        select2,
   input  logic [XLEN-1:0]   wbALU,
   input  logic [XLEN-1:0]   wbALUMem,
   output logic              redirectValid,
   output logic [XLEN-1:0]   redirectAddr,
   output logic [CNT_W-1:0]  branchCount,
   output logic [CNT_W-1:0]  mispredictCount
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = XLEN - INDEX_BITS - 2;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0] LSB_MASK = ~(XLEN'(1));

   // ---------------------------------------------------------------------
   // Predictor storage
   // ---------------------------------------------------------------------
   logic              valid_q [ENTRIES];
   logic              valid_d [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [TAG_W-1:0]  tag_d   [ENTRIES];
   logic [1:0]        cnt_q   [ENTRIES];
   logic [1:0]        cnt_d   [ENTRIES];
   logic [XLEN-1:0]   tgt_q   [ENTRIES];
   logic [XLEN-1:0]   tgt_d   [ENTRIES];

   logic [CNT_W-1:0]  branch_count_q, branch_count_d;
   logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   // ---------------------------------------------------------------------
   // IF lookup (reads registered state only, so a same-cycle update to the
   // same index is not visible until the following cycle)
   // ---------------------------------------------------------------------
   logic [INDEX_BITS-1:0] if_idx;
   logic [TAG_W-1:0]      if_tag;
   logic                  if_hit;

   always_comb begin
      if_idx     = ifPc[INDEX_BITS+1:2];
      if_tag     = ifPc[XLEN-1:INDEX_BITS+2];
      if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      predTaken  = if_hit && cnt_q[if_idx][1];
      predTarget = if_hit ? tgt_q[if_idx] : ifPc + PC_STEP;
   end

   // ---------------------------------------------------------------------
   // ID resolution
   // ---------------------------------------------------------------------
   logic [XLEN-1:0]       rs1, rs2;
   logic                  is_branch, is_jal, is_jalr;
   logic                  illegal_branch, legal_cf, non_cf;
   logic                  cond, taken, mispredict;
   logic [XLEN-1:0]       pc_plus4, pc_rel_tgt, jalr_tgt, target;
   logic [INDEX_BITS-1:0] id_idx;
   logic [TAG_W-1:0]      id_tag;
   logic                  id_hit;

   always_comb begin
      case (select1)
         2'b01:   rs1 = wbALU;
         2'b10:   rs1 = wbALUMem;
         default: rs1 = source1;
      endcase
      case (select2)
         2'b01:   rs2 = wbALU;
         2'b10:   rs2 = wbALUMem;
         default: rs2 = source2;
      endcase
   end

   always_comb begin
      is_branch      = (opcode == OP_BRANCH);
      is_jal         = (opcode == OP_JAL);
      is_jalr        = (opcode == OP_JALR);
      // funct3 010/011 have no branch meaning; treat them as inert
      illegal_branch = is_branch && (funct3[2:1] == 2'b01);
      legal_cf       = (is_branch && !illegal_branch) || is_jal || is_jalr;
      non_cf         = !(is_branch || is_jal || is_jalr);

      case (funct3)
         3'b000:  cond = (rs1 == rs2);
         3'b001:  cond = (rs1 != rs2);
         3'b100:  cond = ($signed(rs1) <  $signed(rs2));
         3'b101:  cond = ($signed(rs1) >= $signed(rs2));
         3'b110:  cond = (rs1 <  rs2);
         3'b111:  cond = (rs1 >= rs2);
         default: cond = 1'b0;
      endcase

      pc_plus4   = idPc + PC_STEP;
      pc_rel_tgt = idPc + immValue;
      jalr_tgt   = (rs1 + immValue) & LSB_MASK;
      target     = is_jalr ? jalr_tgt : pc_rel_tgt;

      taken      = legal_cf && (is_jal || is_jalr || cond);
      mispredict = (taken != idPredTaken) || (taken && (target != idPredTarget));

      // Illegal branches and BTB aliases (non-control-flow predicted taken)
      // both fall back to the sequential PC when a taken prediction was made.
      redirectValid = idValid && (legal_cf ? mispredict : idPredTaken);
      redirectAddr  = taken ? target : pc_plus4;

      id_idx = idPc[INDEX_BITS+1:2];
      id_tag = idPc[XLEN-1:INDEX_BITS+2];
      id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
   end

   // ---------------------------------------------------------------------
   // Training and statistics next-state
   // ---------------------------------------------------------------------
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;

      if (idValid && legal_cf) begin
         if (taken) begin
            valid_d[id_idx] = 1'b1;
            tag_d[id_idx]   = id_tag;
            tgt_d[id_idx]   = target;
            // A newly allocated entry trains from the weakly-not-taken value
            // rather than inheriting the evicted branch's history.
            if (is_branch)
               cnt_d[id_idx] = sat_inc(id_hit ? cnt_q[id_idx] : 2'b01);
            else
               cnt_d[id_idx] = 2'b11;
         end else if (id_hit) begin
            cnt_d[id_idx] = sat_dec(cnt_q[id_idx]);
         end
      end else if (idValid && non_cf && idPredTaken) begin
         valid_d[id_idx] = 1'b0;
      end

      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (idValid && legal_cf)
         branch_count_d = branch_count_q + CNT_W'(1);
      if (redirectValid && !illegal_branch)
         mispredict_count_d = mispredict_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            cnt_q[i]   <= 2'b01;
            tgt_q[i]   <= '0;
         end
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         valid_q            <= valid_d;
         tag_q              <= tag_d;
         cnt_q              <= cnt_d;
         tgt_q              <= tgt_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign branchCount     = branch_count_q;
   assign mispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed scoreboard bench for branch_predict_unit

module tb_branch_predict_unit;

   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ALU  = 7'b0110011;

   logic        clk;
   logic        rst_n;
   logic [31:0] ifPc;
   logic        predTaken;
   logic [31:0] predTarget;
   logic        idValid;
   logic [31:0] idPc;
   logic        idPredTaken;
   logic [31:0] idPredTarget;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] immValue;
   logic [31:0] source1, source2;
   logic [1:0]  select1, select2;
   logic [31:0] wbALU, wbALUMem;
   logic        redirectValid;
   logic [31:0] redirectAddr;
   logic [31:0] branchCount, mispredictCount;

   int total = 0;
   int bad   = 0;
   int eb    = 0;
   int em    = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   branch_predict_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ifPc            (ifPc),
      .predTaken       (predTaken),
      .predTarget      (predTarget),
      .idValid         (idValid),
      .idPc            (idPc),
      .idPredTaken     (idPredTaken),
      .idPredTarget    (idPredTarget),
      .opcode          (opcode),
      .funct3          (funct3),
      .immValue        (immValue),
      .source1         (source1),
      .source2         (source2),
      .select1         (select1),
      .select2         (select2),
      .wbALU           (wbALU),
      .wbALUMem        (wbALUMem),
      .redirectValid   (redirectValid),
      .redirectAddr    (redirectAddr),
      .branchCount     (branchCount),
      .mispredictCount (mispredictCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string n, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_underflow observed=%h expected=<entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
         end
      end
   endtask

   // Drive one ID instruction at the falling edge and check the combinational
   // redirect plus the same-cycle IF lookup; the update lands on the next rise.
   task automatic id_step(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic pt, input logic [31:0] ptgt,
                          input logic [31:0] if_pc,
                          input logic exp_rv, input logic [31:0] exp_ra,
                          input logic exp_pt, input logic chk_addr);
      @(negedge clk);
      idValid      = 1'b1;
      opcode       = op;
      funct3       = f3;
      idPc         = pc;
      immValue     = imm;
      source1      = s1;
      source2      = s2;
      idPredTaken  = pt;
      idPredTarget = ptgt;
      ifPc         = if_pc;
      push("redirect_valid", {31'b0, exp_rv});
      if (chk_addr) push("redirect_addr", exp_ra);
      push("pred_taken_same_cycle", {31'b0, exp_pt});
      #1;
      observe({31'b0, redirectValid});
      if (chk_addr) observe(redirectAddr);
      observe({31'b0, predTaken});
   endtask

   task automatic lookup(input logic [31:0] if_pc, input logic exp_pt,
                         input logic [31:0] exp_tgt, input int exp_bc, input int exp_mc);
      @(negedge clk);
      idValid = 1'b0;
      ifPc    = if_pc;
      push("pred_taken", {31'b0, exp_pt});
      push("pred_target", exp_tgt);
      push("branch_count", exp_bc);
      push("mispredict_count", exp_mc);
      #1;
      observe({31'b0, predTaken});
      observe(predTarget);
      observe(branchCount);
      observe(mispredictCount);
   endtask

   initial begin : stim
      logic pred_seq [4];
      pred_seq[0] = 1'b1;
      pred_seq[1] = 1'b1;
      pred_seq[2] = 1'b0;
      pred_seq[3] = 1'b0;

      rst_n = 1'b0;
      idValid = 1'b0; idPc = '0; idPredTaken = 1'b0; idPredTarget = '0;
      opcode = '0; funct3 = '0; immValue = '0; source1 = '0; source2 = '0;
      select1 = 2'b00; select2 = 2'b00; wbALU = '0; wbALUMem = '0;
      ifPc = 32'h100;

      // Reset state
      #12;
      push("reset_pred_taken", 32'h0);
      push("reset_pred_target", 32'h104);
      push("reset_branch_count", 32'h0);
      push("reset_mispredict_count", 32'h0);
      #1;
      observe({31'b0, predTaken});
      observe(predTarget);
      observe(branchCount);
      observe(mispredictCount);
      @(negedge clk);
      rst_n = 1'b1;

      // BEQ taken, predicted not taken
      id_step(OP_B, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0,
              32'h100, 1'b1, 32'h120, 1'b0, 1'b1);
      eb++; em++;
      lookup(32'h100, 1'b1, 32'h120, eb, em);

      // BLT signed: -1 < 1
      id_step(OP_B, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0,
              32'h200, 1'b1, 32'h240, 1'b0, 1'b1);
      eb++; em++;
      lookup(32'h200, 1'b1, 32'h240, eb, em);

      // BLTU same operands: not taken, predicted taken -> sequential redirect
      id_step(OP_B, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h340,
              32'h300, 1'b1, 32'h304, 1'b0, 1'b1);
      eb++; em++;
      lookup(32'h300, 1'b0, 32'h304, eb, em);
      lookup(32'h200, 1'b1, 32'h240, eb, em);

      // Forwarded operands equal -> BNE not taken, no redirect
      select1 = 2'b01; select2 = 2'b10; wbALU = 32'd7; wbALUMem = 32'd7;
      id_step(OP_B, 3'b001, 32'h400, 32'h10, 32'd0, 32'd0, 1'b0, 32'h0,
              32'h400, 1'b0, 32'h404, 1'b0, 1'b1);
      eb++;
      lookup(32'h400, 1'b0, 32'h404, eb, em);

      // Select 11 uses registers: 1 != 0 -> taken
      select1 = 2'b11; select2 = 2'b11;
      id_step(OP_B, 3'b001, 32'h500, 32'h10, 32'd1, 32'd0, 1'b0, 32'h0,
              32'h500, 1'b1, 32'h510, 1'b0, 1'b1);
      eb++; em++;
      select1 = 2'b00; select2 = 2'b00;

      // JALR clears bit 0 of the target
      id_step(OP_JALR, 3'b000, 32'h600, 32'd4, 32'h1001, 32'd0, 1'b0, 32'h0,
              32'h600, 1'b1, 32'h1004, 1'b0, 1'b1);
      eb++; em++;
      lookup(32'h600, 1'b1, 32'h1004, eb, em);

      // Second JALR correctly predicted
      id_step(OP_JALR, 3'b000, 32'h600, 32'd4, 32'h1001, 32'd0, 1'b1, 32'h1004,
              32'h600, 1'b0, 32'h0, 1'b1, 1'b0);
      eb++;
      lookup(32'h600, 1'b1, 32'h1004, eb, em);

      // Four not-taken BEQs walk the counter 11 -> 10 -> 01 -> 00 -> 00;
      // the same-cycle lookup sees the pre-update prediction each time
      for (int i = 0; i < 4; i++) begin
         id_step(OP_B, 3'b000, 32'h600, 32'hA04, 32'd1, 32'd2, pred_seq[i], 32'h1004,
                 32'h600, pred_seq[i], 32'h604, pred_seq[i], 1'b1);
         eb++;
         if (pred_seq[i]) em++;
      end
      lookup(32'h600, 1'b0, 32'h1004, eb, em);

      // BTB alias on a non-control-flow instruction invalidates the entry
      id_step(OP_ALU, 3'b000, 32'h600, 32'h0, 32'd0, 32'd0, 1'b1, 32'h1004,
              32'h600, 1'b1, 32'h604, 1'b0, 1'b1);
      em++;
      lookup(32'h600, 1'b0, 32'h604, eb, em);

      // Illegal funct3 predicted taken: sequential redirect, no update, no stats
      id_step(OP_B, 3'b010, 32'h700, 32'h40, 32'd3, 32'd3, 1'b1, 32'h740,
              32'h700, 1'b1, 32'h704, 1'b0, 1'b1);
      lookup(32'h700, 1'b0, 32'h704, eb, em);

      // JAL allocates an entry
      id_step(OP_JAL, 3'b000, 32'h800, 32'h100, 32'd0, 32'd0, 1'b0, 32'h0,
              32'h800, 1'b1, 32'h900, 1'b0, 1'b1);
      eb++; em++;
      lookup(32'h800, 1'b1, 32'h900, eb, em);

      // Asynchronous reset in the middle of an update cycle
      @(negedge clk);
      idValid = 1'b1; opcode = OP_JAL; funct3 = 3'b000; idPc = 32'h840;
      immValue = 32'h100; idPredTaken = 1'b0; idPredTarget = 32'h0; ifPc = 32'h800;
      #2;
      rst_n = 1'b0;
      push("async_pred_taken", 32'h0);
      push("async_pred_target", 32'h804);
      push("async_branch_count", 32'h0);
      push("async_mispredict_count", 32'h0);
      push("reset_redirect_valid", 32'h1);
      push("reset_redirect_addr", 32'h940);
      #1;
      observe({31'b0, predTaken});
      observe(predTarget);
      observe(branchCount);
      observe(mispredictCount);
      observe({31'b0, redirectValid});
      observe(redirectAddr);
      @(negedge clk);
      rst_n = 1'b1;
      idValid = 1'b0;
      eb = 0; em = 0;
      lookup(32'h840, 1'b0, 32'h844, eb, em);
      lookup(32'h800, 1'b0, 32'h804, eb, em);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
